// File: rtl/cpu_program_loader_if.sv
// cpu_program_loader_if
//   Program-memory write port plus loader status, driven by the loader
//   (master) and consumed by the CPU top / program memory (slave).
//   prog_address : word address of the current write
//   prog_data    : 12-bit instruction word
//   prog_wren    : one-cycle write strobe per word
//   cpu_hold     : keeps the CPU in reset while a load is in progress
//   load_done    : one-cycle pulse when an image is accepted
//   load_error   : sticky error flag, cleared by the next sync byte
interface cpu_program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] prog_address;
  logic [11:0]           prog_data;
  logic                  prog_wren;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output prog_address, prog_data, prog_wren, cpu_hold, load_done, load_error
  );

  modport slave (
    input prog_address, prog_data, prog_wren, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/cpu_program_loader.sv
// cpu_program_loader
//   UART (8N1) boot loader feeding the CPU program memory write port.
//   Frame: A5, N, {LO, HI} x (N+1), SUM  where word = {HI[3:0], LO} and
//   SUM = (N + all LO/HI bytes) mod 256.
// Ports
//   clk  : system clock
//   rst  : synchronous active-high reset
//   rx   : asynchronous UART line, idles high
//   prog : program memory write port and status (master side)
//
// Receiver states
//   RX_IDLE   | waiting for a falling edge on the synchronised line
//   RX_START  | counting to the middle of the start bit, glitch check
//   RX_DATA   | sampling 8 data bits LSB-first
//   RX_STOP   | sampling the stop bit, emits byte_valid or framing_err
// Protocol states
//   WAIT_SYNC | idle, looking for the 0xA5 sync byte
//   GET_COUNT | next byte is word count minus one
//   GET_LO    | next byte is data[7:0]
//   GET_HI    | next byte is {4'h0, data[11:8]}, word written on accept
//   GET_SUM   | next byte is the 8-bit checksum
module cpu_program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 8,
  parameter int TIMEOUT_CLKS = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  cpu_program_loader_if.master prog
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BW-1:0] HALF_LOAD = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_SYNC, GET_COUNT, GET_LO, GET_HI, GET_SUM} p_state_t;

  // ---------------- byte receiver ----------------
  rx_state_t rx_state, rx_state_nxt;
  logic rx_meta, rx_sync, rx_prev;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic [7:0] rx_shift, rx_shift_nxt;
  logic byte_valid, byte_valid_nxt;
  logic framing_err, framing_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      rx_shift    <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      rx_state    <= rx_state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      rx_shift    <= rx_shift_nxt;
      byte_valid  <= byte_valid_nxt;
      framing_err <= framing_err_nxt;
    end
  end

  always_comb begin
    rx_state_nxt    = rx_state;
    bit_cnt_nxt     = bit_cnt;
    bit_idx_nxt     = bit_idx;
    rx_shift_nxt    = rx_shift;
    byte_valid_nxt  = 1'b0;
    framing_err_nxt = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_nxt = RX_START;
          bit_cnt_nxt  = HALF_LOAD;
        end
      end
      RX_START: begin
        if (bit_cnt != '0) begin
          bit_cnt_nxt = bit_cnt - 1'b1;
        end else if (rx_sync) begin
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_state_nxt = RX_DATA;
          bit_cnt_nxt  = BIT_LOAD;
          bit_idx_nxt  = '0;
        end
      end
      RX_DATA: begin
        if (bit_cnt != '0) begin
          bit_cnt_nxt = bit_cnt - 1'b1;
        end else begin
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          bit_cnt_nxt  = BIT_LOAD;
          if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
          else                 bit_idx_nxt  = bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_cnt != '0) begin
          bit_cnt_nxt = bit_cnt - 1'b1;
        end else begin
          // Returning to idle at mid-stop lets a back-to-back start edge be seen.
          rx_state_nxt    = RX_IDLE;
          byte_valid_nxt  = rx_sync;
          framing_err_nxt = !rx_sync;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------- protocol ----------------
  p_state_t p_state, p_state_nxt;
  logic [7:0] sum, sum_nxt;
  logic [7:0] words_left, words_left_nxt;
  logic [7:0] data_lo, data_lo_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [11:0] data_q, data_nxt;
  logic wren_q, wren_nxt;
  logic hold_q, hold_nxt;
  logic done_q, done_nxt;
  logic err_q, err_nxt;
  logic abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state    <= WAIT_SYNC;
      sum        <= '0;
      words_left <= '0;
      data_lo    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      p_state    <= p_state_nxt;
      sum        <= sum_nxt;
      words_left <= words_left_nxt;
      data_lo    <= data_lo_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      wren_q     <= wren_nxt;
      hold_q     <= hold_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
    end
  end

  // Inter-byte gap timer: reloads on every accepted byte and while idle.
  always_ff @(posedge clk) begin
    if (rst || p_state == WAIT_SYNC || byte_valid) tmo_cnt <= TMO_LOAD;
    else if (tmo_cnt != '0)                          tmo_cnt <= tmo_cnt - 1'b1;
  end

  always_comb begin
    p_state_nxt    = p_state;
    sum_nxt        = sum;
    words_left_nxt = words_left;
    data_lo_nxt    = data_lo;
    addr_nxt       = wren_q ? addr_q + 1'b1 : addr_q;
    data_nxt       = data_q;
    wren_nxt       = 1'b0;
    hold_nxt       = hold_q;
    done_nxt       = 1'b0;
    err_nxt        = err_q;
    abort          = 1'b0;
    case (p_state)
      WAIT_SYNC: begin
        if (byte_valid && rx_shift == 8'hA5) begin
          p_state_nxt = GET_COUNT;
          hold_nxt    = 1'b1;
          err_nxt     = 1'b0;
          addr_nxt    = '0;
          sum_nxt     = '0;
        end
      end
      GET_COUNT: begin
        if (byte_valid) begin
          words_left_nxt = rx_shift;
          sum_nxt        = rx_shift;
          p_state_nxt    = GET_LO;
        end
      end
      GET_LO: begin
        if (byte_valid) begin
          data_lo_nxt = rx_shift;
          sum_nxt     = sum + rx_shift;
          p_state_nxt = GET_HI;
        end
      end
      GET_HI: begin
        if (byte_valid) begin
          if (rx_shift[7:4] != 4'h0) begin
            abort = 1'b1;
          end else begin
            data_nxt = {rx_shift[3:0], data_lo};
            sum_nxt  = sum + rx_shift;
            wren_nxt = 1'b1;
            // words_left holds the count of words still to come after this one.
            if (words_left == 8'd0) begin
              p_state_nxt = GET_SUM;
            end else begin
              words_left_nxt = words_left - 1'b1;
              p_state_nxt    = GET_LO;
            end
          end
        end
      end
      GET_SUM: begin
        if (byte_valid) begin
          if (rx_shift == sum) begin
            done_nxt    = 1'b1;
            hold_nxt    = 1'b0;
            p_state_nxt = WAIT_SYNC;
          end else begin
            abort = 1'b1;
          end
        end
      end
      default: p_state_nxt = WAIT_SYNC;
    endcase
    if (p_state != WAIT_SYNC && (framing_err || (!byte_valid && tmo_cnt == '0)))
      abort = 1'b1;
    if (abort) begin
      err_nxt     = 1'b1;
      hold_nxt    = 1'b1;
      wren_nxt    = 1'b0;
      p_state_nxt = WAIT_SYNC;
    end
  end

  assign prog.prog_address = addr_q;
  assign prog.prog_data    = data_q;
  assign prog.prog_wren    = wren_q;
  assign prog.cpu_hold     = hold_q;
  assign prog.load_done    = done_q;
  assign prog.load_error   = err_q;
endmodule

// File: tb/tb_cpu_program_loader.sv
// Testbench for cpu_program_loader: UART frame driver, frame-level
// reference model feeding expectation queues, and an independent monitor.
module tb_cpu_program_loader;
  localparam int CPB = 16;
  localparam int AW  = 8;
  localparam int TMO = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  always #5 clk = ~clk;

  cpu_program_loader_if #(.ADDR_WIDTH(AW)) pif ();

  cpu_program_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .prog(pif)
  );

  int errors = 0;
  int checks = 0;
  int exp_wr[$];    // (addr << 12) | data
  int exp_evt[$];   // 1 = load_done, 2 = load_error
  int wren_seen = 0;
  bit mdl_hold = 1'b0;
  bit mdl_err  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or status event.
  initial begin : monitor
    logic prev_err;
    int e;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_err = pif.load_error;
      end else begin
        if (pif.prog_wren) begin
          wren_seen++;
          if (exp_wr.size() == 0) check("wren_unexpected", 1, 0);
          else begin
            e = exp_wr.pop_front();
            check("wren_addr_data", (int'(pif.prog_address) << 12) | int'(pif.prog_data), e);
          end
        end
        if (pif.load_done) begin
          if (exp_evt.size() == 0) check("done_unexpected", 1, 0);
          else begin
            e = exp_evt.pop_front();
            check("load_done_event", 1, e);
          end
        end
        if (pif.load_error && !prev_err) begin
          if (exp_evt.size() == 0) check("error_unexpected", 1, 0);
          else begin
            e = exp_evt.pop_front();
            check("load_error_event", 2, e);
          end
        end
        prev_err = pif.load_error;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = good_stop;
    idle(CPB);
    rx = 1'b1;
  endtask

  // Frame-level reference: locate the sync byte, parse fields by position,
  // and derive writes plus the final outcome. Missing bytes mean the line
  // went quiet, which ends in a timeout.
  function automatic void model_frame(input logic [7:0] fr[$], input int bad_stop,
                                      output int sync_pos);
    int n, sum, k, w;
    logic [7:0] b, lo;
    sync_pos = -1;
    for (int i = 0; i < fr.size(); i++)
      if (fr[i] == 8'hA5 && i != bad_stop) begin sync_pos = i; break; end
    if (sync_pos < 0) return;
    mdl_hold = 1'b1;
    mdl_err  = 1'b0;
    n = 0; sum = 0; lo = 8'h00;
    for (int p = sync_pos + 1; p < sync_pos + 1000; p++) begin
      k = p - sync_pos - 1;
      if (p >= fr.size() || p == bad_stop) begin
        mdl_err = 1'b1; exp_evt.push_back(2); return;
      end
      b = fr[p];
      if (k == 0) begin
        n = int'(b); sum = n;
      end else if (k <= 2 * (n + 1)) begin
        if (k % 2 == 1) lo = b;
        else begin
          if (b[7:4] != 4'h0) begin
            mdl_err = 1'b1; exp_evt.push_back(2); return;
          end
          w = (k / 2 - 1) % (1 << AW);
          exp_wr.push_back((w << 12) | (int'(b[3:0]) << 8) | int'(lo));
        end
        sum = sum + int'(b);
      end else begin
        if (int'(b) == sum % 256) begin
          mdl_hold = 1'b0; exp_evt.push_back(1);
        end else begin
          mdl_err = 1'b1; exp_evt.push_back(2);
        end
        return;
      end
    end
  endfunction

  task automatic send_frame(input string tag, input logic [7:0] fr[$], input int bad_stop,
                            input int gap_max, output int waited);
    int s;
    model_frame(fr, bad_stop, s);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], i != bad_stop);
      if (i == s) begin
        idle(2);
        check({tag, "_hold_after_sync"}, int'(pif.cpu_hold), 1);
        check({tag, "_err_after_sync"}, int'(pif.load_error), 0);
      end
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
    end
    waited = 0;
    while ((exp_evt.size() != 0 || exp_wr.size() != 0) && waited < 3000) begin
      idle(1);
      waited++;
    end
    check({tag, "_pending_expectations"}, exp_evt.size() + exp_wr.size(), 0);
    idle(4);
    check({tag, "_cpu_hold"}, int'(pif.cpu_hold), int'(mdl_hold));
    check({tag, "_load_error"}, int'(pif.load_error), int'(mdl_err));
  endtask

  initial begin : stim
    logic [7:0] fr[$];
    int waited, base;

    // Reset
    rst = 1'b1; rx = 1'b1;
    idle(3);
    check("reset_addr", int'(pif.prog_address), 0);
    check("reset_data", int'(pif.prog_data), 0);
    check("reset_wren", int'(pif.prog_wren), 0);
    check("reset_hold", int'(pif.cpu_hold), 0);
    check("reset_done", int'(pif.load_done), 0);
    check("reset_err", int'(pif.load_error), 0);
    rst = 1'b0;
    idle(500);
    check("reset_no_wren", wren_seen, 0);

    // Line noise while idle
    rx = 1'b0; idle(4); rx = 1'b1; idle(40);
    fr = {8'h00, 8'h5A};
    send_frame("noise", fr, -1, 0, waited);
    check("noise_no_wren", wren_seen, 0);

    // Good load
    fr = {8'hA5, 8'h01, 8'h25, 8'h0C, 8'hFF, 8'h0A, 8'h3B};
    send_frame("good", fr, -1, 0, waited);

    // Bad checksum, then a good load clears the flags
    fr = {8'hA5, 8'h00, 8'h12, 8'h03, 8'h00};
    send_frame("bad_sum", fr, -1, 0, waited);
    fr = {8'hA5, 8'h00, 8'h34, 8'h01, 8'h35};
    send_frame("recover", fr, -1, 5, waited);

    // Bad high nibble followed by a stray byte
    base = wren_seen;
    fr = {8'hA5, 8'h00, 8'h12, 8'h13, 8'h15};
    send_frame("bad_nibble", fr, -1, 0, waited);
    check("bad_nibble_no_wren", wren_seen - base, 0);

    // Framing error on the HI byte
    fr = {8'hA5, 8'h00, 8'h12, 8'h03};
    send_frame("framing", fr, 3, 0, waited);

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      int n, kind, bad_w, sum;
      logic [7:0] b, lo, hi;
      logic [31:0] r;
      fr = {};
      if ($urandom_range(1, 0) == 1) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        fr.push_back(b);
      end
      fr.push_back(8'hA5);
      n = $urandom_range(4, 0);
      fr.push_back(8'(n));
      sum = n;
      kind = $urandom_range(4, 0);
      bad_w = $urandom_range(n, 0);
      for (int w = 0; w <= n; w++) begin
        lo = 8'($urandom);
        r = $urandom;
        hi = {4'h0, r[3:0]};
        if (kind == 0 && w == bad_w) hi[7:4] = 4'($urandom_range(15, 1));
        fr.push_back(lo);
        fr.push_back(hi);
        sum = sum + int'(lo) + int'(hi);
        if (kind == 0 && w == bad_w) break;
      end
      if (kind != 0)
        fr.push_back(8'((kind == 1) ? sum + $urandom_range(255, 1) : sum));
      send_frame($sformatf("rand%0d", f), fr, -1, 30, waited);
    end

    // Timeout after the count byte
    fr = {8'hA5, 8'h03};
    send_frame("timeout", fr, -1, 0, waited);
    check("timeout_in_window", int'(waited >= 1900 && waited <= 2100), 1);

    // Reset in the middle of a frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h25, 1'b1);
    idle(3);
    check("midreset_hold_before", int'(pif.cpu_hold), 1);
    rst = 1'b1;
    idle(1);
    check("midreset_hold", int'(pif.cpu_hold), 0);
    check("midreset_err", int'(pif.load_error), 0);
    rst = 1'b0;
    mdl_hold = 1'b0;
    mdl_err  = 1'b0;
    idle(20);

    fr = {8'hA5, 8'h00, 8'hA5, 8'h0F, 8'hB4};
    send_frame("final", fr, -1, 0, waited);

    idle(50);
    check("final_queues_empty", exp_evt.size() + exp_wr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
